// File: rtl/penguen_koloni_if.sv
// Bus bundle for the penguin colony feeding tracker.
// Carries the start pulse, per-channel fish inputs and all registered results.
//   master: drives basla, balik_gecerli, avlanan_balik; observes results
//   slave : the tracker; consumes fish inputs, drives results
interface penguen_koloni_if #(
  parameter int unsigned KANAL   = 4,
  parameter int unsigned BALIK_W = 3,
  parameter int unsigned SAYAC_W = 8
);
  localparam int unsigned IdxW = (KANAL > 1) ? $clog2(KANAL) : 1;

  logic                       basla;
  logic [KANAL-1:0]           balik_gecerli;
  logic [KANAL*BALIK_W-1:0]   avlanan_balik;
  logic [KANAL-1:0]           bitti;
  logic [KANAL*SAYAC_W-1:0]   bitme_sure;
  logic [IdxW-1:0]            ilk_biten;
  logic                       ilk_gecerli;
  logic                       hepsi_bitti;
  logic                       zaman_asimi;

  modport master (
    output basla, balik_gecerli, avlanan_balik,
    input  bitti, bitme_sure, ilk_biten, ilk_gecerli, hepsi_bitti, zaman_asimi
  );

  modport slave (
    input  basla, balik_gecerli, avlanan_balik,
    output bitti, bitme_sure, ilk_biten, ilk_gecerli, hepsi_bitti, zaman_asimi
  );
endinterface

// File: rtl/penguen_koloni.sv
// Multi-channel penguin feeding tracker.
// Tracks KANAL stomachs fed by valid-qualified fish, latches each channel's finish time and
// the first finisher, and flags colony completion or counter timeout.
// Ports:
//   saat  : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : penguen_koloni_if.slave (basla, fish inputs in; registered results out)
// Build option: define PENGUEN_SINDIRIM_EN to enable periodic digestion
//   (SINDIRIM_MIKTAR removed every SINDIRIM_PERYOT AV cycles, saturating at 0).
module penguen_koloni #(
  parameter int unsigned KANAL           = 4,
  parameter int unsigned BALIK_W         = 3,
  parameter int unsigned MIDE_W          = 6,
  parameter int unsigned KAPASITE        = 25,
  parameter int unsigned SINDIRIM_PERYOT = 3,
  parameter int unsigned SINDIRIM_MIKTAR = 3,
  parameter int unsigned SAYAC_W         = 8
) (
  input  logic              saat,
  input  logic              reset,
  penguen_koloni_if.slave   bus
);

  localparam int unsigned IdxW = (KANAL > 1) ? $clog2(KANAL) : 1;
  localparam logic [MIDE_W:0] Kapasite = (MIDE_W+1)'(KAPASITE);

  typedef enum logic [1:0] {StBos, StAv, StSon} durum_e;

  durum_e                     state_q, state_d;
  logic [SAYAC_W-1:0]         sayac_q, sayac_d;
  logic [MIDE_W-1:0]          mide_q [KANAL];
  logic [MIDE_W-1:0]          mide_d [KANAL];
  logic [KANAL-1:0]           bitti_q, bitti_d;
  logic [KANAL*SAYAC_W-1:0]   bitme_sure_q, bitme_sure_d;
  logic [IdxW-1:0]            ilk_biten_q, ilk_biten_d;
  logic                       ilk_gecerli_q, ilk_gecerli_d;
  logic                       hepsi_bitti_q, hepsi_bitti_d;
  logic                       zaman_asimi_q, zaman_asimi_d;

  // Per-channel datapath: gated fish, stomach+fish sum, and post-digestion remainder.
  logic [MIDE_W:0]            toplam [KANAL];
  logic [MIDE_W-1:0]          kalan  [KANAL];
  logic                       sindir;

`ifdef PENGUEN_SINDIRIM_EN
  localparam int unsigned PerW = (SINDIRIM_PERYOT > 1) ? $clog2(SINDIRIM_PERYOT) : 1;
  localparam logic [PerW-1:0] PerSon = PerW'(SINDIRIM_PERYOT - 1);
  localparam logic [MIDE_W:0] Miktar = (MIDE_W+1)'(SINDIRIM_MIKTAR);

  // Phase counter runs in lockstep with sayac, so faz == sayac % SINDIRIM_PERYOT
  // without a divider.
  logic [PerW-1:0] faz_q, faz_d;

  assign sindir = (faz_q == PerSon);

  always_comb begin
    faz_d = faz_q;
    if (state_q == StAv) begin
      faz_d = sindir ? '0 : faz_q + 1'b1;
    end else if (bus.basla) begin
      faz_d = '0;
    end
  end

  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      faz_q <= '0;
    end else begin
      faz_q <= faz_d;
    end
  end
`else
  logic unused_sindirim;
  assign unused_sindirim = ^{SINDIRIM_PERYOT, SINDIRIM_MIKTAR};
  assign sindir = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < KANAL; i++) begin
      toplam[i] = {1'b0, mide_q[i]};
      if (bus.balik_gecerli[i]) begin
        toplam[i] = {1'b0, mide_q[i]} + (MIDE_W+1)'(bus.avlanan_balik[i*BALIK_W +: BALIK_W]);
      end
      // Only used when toplam < KAPASITE, so the MIDE_W truncation is lossless.
      kalan[i] = toplam[i][MIDE_W-1:0];
`ifdef PENGUEN_SINDIRIM_EN
      if (sindir) begin
        kalan[i] = (toplam[i] > Miktar) ? MIDE_W'(toplam[i] - Miktar) : '0;
      end
`endif
    end
  end

  logic [KANAL-1:0] yeni_bitis;
  logic [IdxW-1:0]  ilk_aday;

  always_comb begin
    state_d       = state_q;
    sayac_d       = sayac_q;
    mide_d        = mide_q;
    bitti_d       = bitti_q;
    bitme_sure_d  = bitme_sure_q;
    ilk_biten_d   = ilk_biten_q;
    ilk_gecerli_d = ilk_gecerli_q;
    hepsi_bitti_d = hepsi_bitti_q;
    zaman_asimi_d = zaman_asimi_q;
    yeni_bitis    = '0;
    ilk_aday      = '0;

    unique case (state_q)
      StBos, StSon: begin
        if (bus.basla) begin
          state_d       = StAv;
          sayac_d       = '0;
          mide_d        = '{default: '0};
          bitti_d       = '0;
          bitme_sure_d  = '0;
          ilk_biten_d   = '0;
          ilk_gecerli_d = 1'b0;
          hepsi_bitti_d = 1'b0;
          zaman_asimi_d = 1'b0;
        end
      end

      StAv: begin
        for (int i = 0; i < KANAL; i++) begin
          if (!bitti_q[i]) begin
            if (toplam[i] >= Kapasite) begin
              // Finishing channel keeps its stomach value; only the flag and time latch.
              yeni_bitis[i]                        = 1'b1;
              bitti_d[i]                           = 1'b1;
              bitme_sure_d[i*SAYAC_W +: SAYAC_W]   = sayac_q + 1'b1;
            end else begin
              mide_d[i] = kalan[i];
            end
          end
        end

        // Descending scan so the lowest finishing index wins ties.
        for (int i = KANAL - 1; i >= 0; i--) begin
          if (yeni_bitis[i]) begin
            ilk_aday = IdxW'(i);
          end
        end
        if (!ilk_gecerli_q && (|yeni_bitis)) begin
          ilk_gecerli_d = 1'b1;
          ilk_biten_d   = ilk_aday;
        end

        if (&bitti_d) begin
          state_d       = StSon;
          hepsi_bitti_d = 1'b1;
        end else if (sayac_q == '1) begin
          state_d       = StSon;
          zaman_asimi_d = 1'b1;
        end else begin
          sayac_d = sayac_q + 1'b1;
        end
      end

      default: begin
        state_d = StBos;
      end
    endcase
  end

  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      state_q       <= StBos;
      sayac_q       <= '0;
      mide_q        <= '{default: '0};
      bitti_q       <= '0;
      bitme_sure_q  <= '0;
      ilk_biten_q   <= '0;
      ilk_gecerli_q <= 1'b0;
      hepsi_bitti_q <= 1'b0;
      zaman_asimi_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sayac_q       <= sayac_d;
      mide_q        <= mide_d;
      bitti_q       <= bitti_d;
      bitme_sure_q  <= bitme_sure_d;
      ilk_biten_q   <= ilk_biten_d;
      ilk_gecerli_q <= ilk_gecerli_d;
      hepsi_bitti_q <= hepsi_bitti_d;
      zaman_asimi_q <= zaman_asimi_d;
    end
  end

  assign bus.bitti       = bitti_q;
  assign bus.bitme_sure  = bitme_sure_q;
  assign bus.ilk_biten   = ilk_biten_q;
  assign bus.ilk_gecerli = ilk_gecerli_q;
  assign bus.hepsi_bitti = hepsi_bitti_q;
  assign bus.zaman_asimi = zaman_asimi_q;

endmodule

// File: tb/tb_penguen_koloni.sv
// Scoreboard bench for penguen_koloni: per-run stimulus tables, a per-channel reference
// model, and a monitor that checks results when the colony run ends.
module tb_penguen_koloni;

  localparam int KANAL   = 4;
  localparam int BALIK_W = 3;
  localparam int MIDE_W  = 6;
  localparam int KAP     = 25;
  localparam int PER     = 3;
  localparam int MIK     = 3;
  localparam int SAYAC_W = 8;
  localparam int IdxW    = (KANAL > 1) ? $clog2(KANAL) : 1;
  localparam int NCYC    = 300;
  localparam int SMAX    = (1 << SAYAC_W) - 1;

  typedef struct packed {
    logic [KANAL-1:0]         bitti;
    logic [KANAL*SAYAC_W-1:0] sure;
    logic                     ilk_g;
    logic [IdxW-1:0]          ilk;
    logic                     hepsi;
    logic                     zaman;
  } exp_t;

  logic saat;
  logic reset;

  penguen_koloni_if #(.KANAL(KANAL), .BALIK_W(BALIK_W), .SAYAC_W(SAYAC_W)) bus ();

  penguen_koloni #(
    .KANAL(KANAL), .BALIK_W(BALIK_W), .MIDE_W(MIDE_W), .KAPASITE(KAP),
    .SINDIRIM_PERYOT(PER), .SINDIRIM_MIKTAR(MIK), .SAYAC_W(SAYAC_W)
  ) dut (
    .saat  (saat),
    .reset (reset),
    .bus   (bus)
  );

  initial saat = 1'b0;
  always #5 saat = ~saat;

  int   vectors;
  int   miscompares;
  exp_t sb_q[$];
  bit   mon_done;

  bit [KANAL-1:0]   stim_v [NCYC];
  bit [BALIK_W-1:0] stim_f [NCYC][KANAL];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, "_bitti"},       64'(bus.bitti),       64'(e.bitti));
    chk({tag, "_bitme_sure"},  64'(bus.bitme_sure),  64'(e.sure));
    chk({tag, "_ilk_gecerli"}, 64'(bus.ilk_gecerli), 64'(e.ilk_g));
    chk({tag, "_ilk_biten"},   64'(bus.ilk_biten),   64'(e.ilk));
    chk({tag, "_hepsi_bitti"}, 64'(bus.hepsi_bitti), 64'(e.hepsi));
    chk({tag, "_zaman_asimi"}, 64'(bus.zaman_asimi), 64'(e.zaman));
  endtask

  // mode 0: ch0 fish 5; 1: ch1/ch3 fish 7, ch0/ch2 fish 0; 2: all fish 7;
  // 3: ch2 never valid, others fish 7; otherwise random per-channel density.
  task automatic gen_stim(input int mode);
    int dens [KANAL];
    for (int c = 0; c < KANAL; c++) begin
      case ($urandom_range(0, 3))
        0:       dens[c] = 0;
        1:       dens[c] = 20;
        2:       dens[c] = 50;
        default: dens[c] = 90;
      endcase
    end
    for (int t = 0; t < NCYC; t++) begin
      for (int c = 0; c < KANAL; c++) begin
        stim_f[t][c] = BALIK_W'($urandom_range(0, 7));
        case (mode)
          0: begin stim_v[t][c] = (c == 0); if (c == 0) stim_f[t][c] = 5; end
          1: begin stim_v[t][c] = 1'b1; stim_f[t][c] = (c == 1 || c == 3) ? 3'd7 : 3'd0; end
          2: begin stim_v[t][c] = 1'b1; stim_f[t][c] = 7; end
          3: begin stim_v[t][c] = (c != 2); if (c != 2) stim_f[t][c] = 7; end
          default: stim_v[t][c] = ($urandom_range(0, 99) < dens[c]);
        endcase
      end
    end
  endtask

  // Each channel evolves independently: find the AV cycle (sayac value) at which it finishes.
  task automatic model(output exp_t e, output int endc);
    int fin [KANAL];
    int mide;
    int f;
    int best;
    bit all_fin;
    e = '0;
    all_fin = 1'b1;
    for (int c = 0; c < KANAL; c++) begin
      fin[c] = -1;
      mide = 0;
      for (int t = 0; t <= SMAX; t++) begin
        f = stim_v[t][c] ? int'(stim_f[t][c]) : 0;
        if (mide + f >= KAP) begin
          fin[c] = t;
          break;
        end
        mide = mide + f;
`ifdef PENGUEN_SINDIRIM_EN
        if (t % PER == PER - 1) mide = (mide > MIK) ? mide - MIK : 0;
`endif
      end
      if (fin[c] < 0) all_fin = 1'b0;
    end
    endc = SMAX;
    if (all_fin) begin
      endc = 0;
      for (int c = 0; c < KANAL; c++) if (fin[c] > endc) endc = fin[c];
    end
    best = SMAX + 1;
    for (int c = 0; c < KANAL; c++) begin
      if (fin[c] >= 0) begin
        e.bitti[c] = 1'b1;
        e.sure[c*SAYAC_W +: SAYAC_W] = SAYAC_W'((fin[c] + 1) % (SMAX + 1));
        if (fin[c] < best) begin
          best    = fin[c];
          e.ilk   = IdxW'(c);
          e.ilk_g = 1'b1;
        end
      end
    end
    e.hepsi = all_fin;
    e.zaman = !all_fin;
  endtask

  task automatic drive(input int k);
    for (int c = 0; c < KANAL; c++) begin
      bus.balik_gecerli[c]                   = stim_v[k][c];
      bus.avlanan_balik[c*BALIK_W +: BALIK_W] = stim_f[k][c];
    end
  endtask

  task automatic run(input int mode, input bit noise);
    exp_t e;
    int   endc;
    int   n;
    gen_stim(mode);
    model(e, endc);
    @(negedge saat);
    bus.basla = 1'b1;
    drive(0);
    @(posedge saat);
    #1;
    bus.basla = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    // First AV cycle: previous results must be cleared.
    chk_all("clear", '0);
    sb_q.push_back(e);
    for (int k = 1; k <= endc + 5; k++) begin
      @(posedge saat);
      #1;
      drive(k);
      bus.basla = (noise && k <= endc) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    n = 0;
    while (!mon_done && n < 50) begin
      @(posedge saat);
      n++;
    end
    chk("monitor_handshake", 64'(mon_done), 64'd1);
    mon_done = 1'b0;
  endtask

  // Monitor: waits for the colony to report an outcome, then checks result and hold.
  initial begin
    exp_t e;
    int   n;
    mon_done = 1'b0;
    forever begin
      @(negedge saat);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n = 0;
        while (!(bus.hepsi_bitti || bus.zaman_asimi) && n < 400) begin
          @(negedge saat);
          n++;
        end
        chk("run_ended", 64'(bus.hepsi_bitti || bus.zaman_asimi), 64'd1);
        chk_all("done", e);
        repeat (3) @(negedge saat);
        chk_all("hold", e);
        mon_done = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   endc;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    bus.basla   = 1'b0;
    bus.balik_gecerli = '0;
    bus.avlanan_balik = '0;
    repeat (2) @(negedge saat);
    chk_all("reset", '0);
    reset = 1'b1;

    run(0, 1'b0);
    run(1, 1'b1);
    run(2, 1'b0);
    run(3, 1'b1);

    // Async reset mid-run with basla held high throughout.
    gen_stim(3);
    model(e, endc);
    @(negedge saat);
    bus.basla = 1'b1;
    drive(0);
    @(posedge saat);
    #1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge saat);
      #1;
      drive(k);
    end
    // Six AV edges: ch0/1/3 have finished, ch2 never will, so the run is still in AV.
    chk("basla_ignored_bitti", 64'(bus.bitti), 64'(e.bitti));
    chk("basla_ignored_sure",  64'(bus.bitme_sure), 64'(e.sure));
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", '0);
    @(negedge saat);
    chk_all("reset_held", '0);
    bus.basla = 1'b0;
    reset     = 1'b1;

    run(2, 1'b1);
    for (int r = 0; r < 14; r++) begin
      run(4 + r, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
